// File: rtl/wt_store_coalesce_buf.sv
// Store write-combining buffer that sits in front of the write-through L1 memory port.
// Committed stores are queued in a circular FIFO. A new store merges into the youngest
// entry when it targets the same doubleword. Entries drain in order, and the number of
// issued but unacknowledged writes is capped at MAX_OUT.
module wt_store_coalesce_buf #(
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 64,
  parameter int MAX_OUT     = 7,
  parameter bit COALESCE_EN = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [ADDR_W-1:0]                req_addr_i,
  input  logic [63:0]                      req_data_i,
  input  logic [7:0]                       req_be_i,
  output logic                             mem_valid_o,
  input  logic                             mem_ready_i,
  output logic [ADDR_W-1:0]                mem_addr_o,
  output logic [63:0]                      mem_data_o,
  output logic [7:0]                       mem_be_o,
  input  logic                             mem_ack_i,
  output logic                             full_o,
  output logic                             empty_o,
  output logic [$clog2(MAX_OUT+1)-1:0]     outstanding_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int TAG_W = ADDR_W - 3;

  // Entry storage. Only the doubleword tag of each address is kept.
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [63:0]      data_q [DEPTH];
  logic [7:0]       be_q   [DEPTH];

  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] count_q;
  logic [OUT_W-1:0] out_q;

  logic [PTR_W-1:0] young_ptr;
  logic             full;
  logic             hit;
  logic             push;
  logic             push_new;
  logic             pop;
  logic             ack_take;

  // The low three address bits only select lanes, which req_be_i already describes.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^req_addr_i[2:0];

  assign young_ptr = wptr_q - PTR_W'(1);
  assign full      = (count_q == CNT_W'(DEPTH));

  // With fewer than two entries the youngest is the head, whose payload must stay stable
  // while it is offered to memory, so it is never a merge target.
  assign hit = COALESCE_EN && (count_q >= CNT_W'(2)) &&
               (req_addr_i[ADDR_W-1:3] == tag_q[young_ptr]);

  assign req_ready_o = hit || !full;
  assign push        = req_valid_i && req_ready_o;
  assign push_new    = push && !hit;

  assign mem_valid_o = (count_q != '0) && (out_q < OUT_W'(MAX_OUT));
  assign pop         = mem_valid_o && mem_ready_i;

  // A stray ack with nothing outstanding is dropped so the counter cannot underflow.
  assign ack_take = mem_ack_i && (out_q != '0);

  assign mem_addr_o    = {tag_q[rptr_q], 3'b000};
  assign mem_data_o    = data_q[rptr_q];
  assign mem_be_o      = be_q[rptr_q];
  assign full_o        = full;
  assign empty_o       = (count_q == '0) && (out_q == '0);
  assign outstanding_o = out_q;

  // Pointer, occupancy, outstanding-counter and storage update.
  always_ff @(posedge clk_i) begin
    // NOTE: every register here, including the storage array, is cleared on reset.
    // This makes mem_*_o read as zero afterwards, and it forces the array into flops
    // instead of a RAM macro.
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments here. Every read in this block sees the pre-edge
      // value. The merge target and the pop decision therefore come from the same
      // registered state that drove req_ready_o and mem_valid_o.
      if (push_new) begin
        tag_q[wptr_q]  <= req_addr_i[ADDR_W-1:3];
        data_q[wptr_q] <= req_data_i;
        be_q[wptr_q]   <= req_be_i;
        wptr_q         <= wptr_q + PTR_W'(1);
      end else if (push) begin
        for (int b = 0; b < 8; b++) begin
          if (req_be_i[b]) data_q[young_ptr][8*b +: 8] <= req_data_i[8*b +: 8];
        end
        be_q[young_ptr] <= be_q[young_ptr] | req_be_i;
      end

      if (pop) rptr_q <= rptr_q + PTR_W'(1);

      case ({push_new, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      case ({pop, ack_take})
        2'b10:   out_q <= out_q + OUT_W'(1);
        2'b01:   out_q <= out_q - OUT_W'(1);
        default: out_q <= out_q;
      endcase
    end
  end

endmodule

// File: tb/tb_wt_store_coalesce_buf.sv
// Self-checking bench for wt_store_coalesce_buf.
// It combines a vector table, hand-written corner sequences and random traffic. All of
// it is checked against a queue-based reference model.
module tb_wt_store_coalesce_buf;

  localparam int DEPTH   = 8;
  localparam int MAX_OUT = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [7:0]  req_be;
  logic        mem_ready;
  logic        mem_ack;

  logic        req_ready, mem_valid, full, empty;
  logic [63:0] mem_addr, mem_data;
  logic [7:0]  mem_be;
  logic [2:0]  outstanding;

  logic        nc_req_ready, nc_mem_valid, nc_full, nc_empty;
  logic [63:0] nc_mem_addr, nc_mem_data;
  logic [7:0]  nc_mem_be;
  logic [2:0]  nc_outstanding;

  wt_store_coalesce_buf #(.DEPTH(DEPTH), .ADDR_W(64), .MAX_OUT(MAX_OUT), .COALESCE_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_be_i(req_be),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .mem_be_o(mem_be), .mem_ack_i(mem_ack),
    .full_o(full), .empty_o(empty), .outstanding_o(outstanding)
  );

  wt_store_coalesce_buf #(.DEPTH(DEPTH), .ADDR_W(64), .MAX_OUT(MAX_OUT), .COALESCE_EN(1'b0)) dut_nc (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(nc_req_ready), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_be_i(req_be),
    .mem_valid_o(nc_mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(nc_mem_addr),
    .mem_data_o(nc_mem_data), .mem_be_o(nc_mem_be), .mem_ack_i(mem_ack),
    .full_o(nc_full), .empty_o(nc_empty), .outstanding_o(nc_outstanding)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the pending entries in order, plus a count of unacknowledged writes.
  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } ent_t;
  ent_t        mq[$];
  int          mout;
  bit          allow_stray;
  int          hs_count;
  int          acc_count;
  logic [63:0] popped[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] be, input logic mr, input logic ak, input logic rs);
    req_valid = v; req_addr = a; req_data = d; req_be = be;
    mem_ready = mr; mem_ack = ak; rst = rs;
  endtask

  // Compares the DUT outputs with the model, advances the model across the coming edge,
  // and then returns one time unit after that edge.
  task automatic settle_and_advance();
    bit   hit, e_ready, e_mvalid;
    int   m0;
    ent_t t;
    m0       = mout;
    hit      = (mq.size() >= 2) && (mq[$].addr[63:3] == req_addr[63:3]);
    e_ready  = hit || (mq.size() < DEPTH);
    e_mvalid = (mq.size() > 0) && (mout < MAX_OUT);
    check("m_ready", req_ready, e_ready);
    check("m_mvalid", mem_valid, e_mvalid);
    check("m_full", full, mq.size() == DEPTH);
    check("m_empty", empty, (mq.size() == 0) && (mout == 0));
    check("m_outstanding", outstanding, mout);
    if (e_mvalid) begin
      check("m_addr", mem_addr, mq[0].addr);
      check("m_data", mem_data, mq[0].data);
      check("m_be", mem_be, mq[0].be);
    end
    if (mem_valid && mem_ready) begin
      hs_count++;
      popped.push_back(mem_addr);
    end
    if (mem_ack && mout == 0 && !allow_stray && !rst) begin
      bad++;
      $display("FAIL stray_ack: ack with nothing outstanding at %0t", $time);
    end
    if (rst) begin
      mq.delete();
      mout = 0;
    end else begin
      if (e_mvalid && mem_ready) begin
        void'(mq.pop_front());
        mout++;
      end
      if (req_valid && e_ready) begin
        acc_count++;
        if (hit) begin
          t = mq[mq.size()-1];
          for (int b = 0; b < 8; b++)
            if (req_be[b]) t.data[8*b +: 8] = req_data[8*b +: 8];
          t.be = t.be | req_be;
          mq[mq.size()-1] = t;
        end else begin
          t.addr = {req_addr[63:3], 3'b000};
          t.data = req_data;
          t.be   = req_be;
          mq.push_back(t);
        end
      end
      if (mem_ack && m0 > 0) mout--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic [63:0] a, input logic [63:0] d,
                      input logic [7:0] be, input logic mr, input logic ak, input logic rs);
    drive(v, a, d, be, mr, ak, rs);
    #4;
    settle_and_advance();
  endtask

  task automatic do_reset();
    drive(1'b0, 64'h0, 64'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    mout = 0;
    hs_count = 0;
    acc_count = 0;
    popped.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, req_ready, 1'b1);
    check({tag, "_mvalid"}, mem_valid, 1'b0);
    check({tag, "_maddr"}, mem_addr, 64'h0);
    check({tag, "_mdata"}, mem_data, 64'h0);
    check({tag, "_mbe"}, mem_be, 8'h0);
    check({tag, "_full"}, full, 1'b0);
    check({tag, "_empty"}, empty, 1'b1);
    check({tag, "_out"}, outstanding, 3'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((mq.size() != 0 || mout != 0) && n < 200) begin
      step(1'b0, 64'h0, 64'h0, 8'h0, 1'b1, mout > 0, 1'b0);
      n++;
    end
    check({tag, "_drained_empty"}, empty, 1'b1);
  endtask

  typedef struct {
    logic        v;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic        mr;
    logic        ack;
    logic        e_ready;
    logic        e_mvalid;
    logic [63:0] e_maddr;
    logic [63:0] e_mdata;
    logic [7:0]  e_mbe;
    logic        e_full;
    logic        e_empty;
    logic [2:0]  e_out;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_addr[8];
    logic [63:0] d;

    // Expected outputs are those seen in the cycle the row's inputs are applied.
    tbl[0]  = '{1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, 1'b0,
                1'b1, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b1, 3'd0};
    tbl[1]  = '{1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 1'b0,
                1'b1, 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, 1'b0, 3'd0};
    tbl[2]  = '{1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b1,
                1'b1, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0, 3'd1};
    tbl[3]  = '{1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0,
                1'b1, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b1, 3'd0};
    tbl[4]  = '{1'b1, 64'h100, 64'h0000_0000_AABB_CCDD, 8'h0F, 1'b0, 1'b0,
                1'b1, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b1, 3'd0};
    tbl[5]  = '{1'b1, 64'h200, 64'h0000_0000_5566_7788, 8'h0F, 1'b0, 1'b0,
                1'b1, 1'b1, 64'h100, 64'h0000_0000_AABB_CCDD, 8'h0F, 1'b0, 1'b0, 3'd0};
    tbl[6]  = '{1'b1, 64'h204, 64'h1122_3344_0000_0000, 8'hF0, 1'b0, 1'b0,
                1'b1, 1'b1, 64'h100, 64'h0000_0000_AABB_CCDD, 8'h0F, 1'b0, 1'b0, 3'd0};
    tbl[7]  = '{1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 1'b0,
                1'b1, 1'b1, 64'h100, 64'h0000_0000_AABB_CCDD, 8'h0F, 1'b0, 1'b0, 3'd0};
    tbl[8]  = '{1'b0, 64'h0, 64'h0, 8'h00, 1'b1, 1'b0,
                1'b1, 1'b1, 64'h200, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, 1'b0, 3'd1};
    tbl[9]  = '{1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b1,
                1'b1, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0, 3'd2};
    tbl[10] = '{1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b1,
                1'b1, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0, 3'd1};
    tbl[11] = '{1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b0,
                1'b1, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 1'b1, 3'd0};

    allow_stray = 1'b0;
    do_reset();
    check_reset_values("reset");

    // Single store followed by the coalesce scenario, driven from the vector table.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].addr, tbl[i].data, tbl[i].be, tbl[i].mr, tbl[i].ack, 1'b0);
      #4;
      check($sformatf("tbl%0d_ready", i), req_ready, tbl[i].e_ready);
      check($sformatf("tbl%0d_mvalid", i), mem_valid, tbl[i].e_mvalid);
      check($sformatf("tbl%0d_full", i), full, tbl[i].e_full);
      check($sformatf("tbl%0d_empty", i), empty, tbl[i].e_empty);
      check($sformatf("tbl%0d_out", i), outstanding, tbl[i].e_out);
      if (tbl[i].e_mvalid) begin
        check($sformatf("tbl%0d_maddr", i), mem_addr, tbl[i].e_maddr);
        check($sformatf("tbl%0d_mdata", i), mem_data, tbl[i].e_mdata);
        check($sformatf("tbl%0d_mbe", i), mem_be, tbl[i].e_mbe);
      end
      settle_and_advance();
    end
    // Without coalescing the same stimulus left a third entry, which is now at the head.
    check("nc_third_valid", nc_mem_valid, 1'b1);
    check("nc_third_addr", nc_mem_addr, 64'h204 & ~64'h7);
    check("nc_third_be", nc_mem_be, 8'hF0);
    check("nc_third_data", nc_mem_data, 64'h1122_3344_0000_0000);
    check("nc_not_empty", nc_empty, 1'b0);

    // When count is 1, a push to the same doubleword must create a new entry.
    do_reset();
    step(1'b1, 64'h700, 64'h0000_0000_0102_0304, 8'h0F, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h704, 64'h0506_0708_0000_0000, 8'hF0, 1'b0, 1'b0, 1'b0);
    drain("cnt1");
    check("cnt1_two_entries", popped.size(), 2);

    // Full backpressure, then an in-order drain.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exp_addr[i] = 64'h1000 + 64'(i) * 8;
      step(1'b1, exp_addr[i], {$urandom, $urandom}, 8'h0F, 1'b0, 1'b0, 1'b0);
    end
    check("full_set", full, 1'b1);
    drive(1'b1, 64'h1000 + 7 * 8 + 5, 64'hFF00_0000_0000_0000, 8'h80, 1'b0, 1'b0, 1'b0);
    #4;
    check("full_hit_ready", req_ready, 1'b1);
    settle_and_advance();
    drive(1'b1, 64'h2000, 64'h1234, 8'hFF, 1'b1, 1'b0, 1'b0);
    #4;
    check("full_miss_ready", req_ready, 1'b0);
    settle_and_advance();
    drain("full");
    check("full_drain_count", popped.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < popped.size()) check($sformatf("full_order%0d", i), popped[i], exp_addr[i]);

    // Outstanding cap.
    do_reset();
    for (int i = 0; i < 9; i++)
      step(1'b1, 64'h3000 + 64'(i) * 8, {$urandom, $urandom}, 8'hFF, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'h0, 64'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    check("cap_handshakes", hs_count, 7);
    check("cap_mvalid_low", mem_valid, 1'b0);
    check("cap_out7", outstanding, 3'd7);
    step(1'b0, 64'h0, 64'h0, 8'h0, 1'b1, 1'b1, 1'b0);
    check("cap_reissue_valid", mem_valid, 1'b1);
    check("cap_out6", outstanding, 3'd6);
    step(1'b0, 64'h0, 64'h0, 8'h0, 1'b1, 1'b1, 1'b0);
    check("cap_issue_ack_out", outstanding, 3'd6);
    check("cap_handshakes8", hs_count, 8);
    drain("cap");

    // Random traffic across pointer wrap, with immediate acks.
    do_reset();
    for (int n = 0; n < 2000 && acc_count < 20; n++) begin
      d = {$urandom, $urandom};
      step($urandom_range(0, 3) != 0,
           64'h4000 + 64'($urandom_range(0, 3)) * 8 + 64'($urandom_range(0, 7)),
           d, 8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), mout > 0, 1'b0);
    end
    check("rand_accepted20", acc_count >= 20, 1'b1);
    for (int n = 0; n < 300; n++) begin
      d = {$urandom, $urandom};
      step($urandom_range(0, 1) != 0,
           64'h4000 + 64'($urandom_range(0, 2)) * 8 + 64'($urandom_range(0, 7)),
           d, 8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)),
           (mout > 0) && ($urandom_range(0, 2) != 0), 1'b0);
    end
    drain("rand");

    // Reset mid-operation with 5 queued and 3 outstanding.
    do_reset();
    for (int i = 0; i < 8; i++)
      step(1'b1, 64'h5000 + 64'(i) * 8, {$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 64'h0, 64'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    check("midrst_out3", outstanding, 3'd3);
    step(1'b0, 64'h0, 64'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    check_reset_values("midrst");
    allow_stray = 1'b1;
    step(1'b0, 64'h0, 64'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    allow_stray = 1'b0;
    check("stray_ack_out0", outstanding, 3'd0);
    check("stray_ack_empty", empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
